dm_dual_param: RTL and testbench
================================

# dm_dual_param

Parametrised, dual-ported data memory for the processor's data path. Port A is the CPU load/store port with byte enables; port B is a read-only port for the accelerator or debug readback. After reset, an internal sequencer clears the array to zero. Collisions and illegal requests have defined outcomes, and write-to-read forwarding across ports is available as a build option.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 13, address width in bits
- DEPTH, 8192, number of words; must be ≤ 2**ADDR_W
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- a_addr  in  ADDR_W  port A word address
- a_re  in  1  port A read request
- a_we  in  1  port A write request
- a_be  in  DATA_W/8  port A byte enables; bit i selects byte lane [8i+7:8i]
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data, registered
- a_rvalid  out  1  port A read data valid, one-cycle pulse
- a_err  out  1  port A illegal request, one-cycle pulse
- b_addr  in  ADDR_W  port B word address
- b_re  in  1  port B read request
- b_rdata  out  DATA_W  port B read data, registered
- b_rvalid  out  1  port B read data valid, one-cycle pulse
- init_busy  out  1  high while the clear sequencer runs

## Operation
- FSM states: INIT and RUN.
- When rst is asserted, the FSM enters INIT and the clear counter is set to 0.
- In INIT:
  - Each cycle writes all-zero data to mem[cnt], then increments cnt.
  - When cnt == DEPTH-1 is written, the FSM moves to RUN on the next edge.
- In INIT, all port requests are ignored: no writes, rvalid stays 0, err stays 0.
- In RUN, a port A write occurs when a_we=1, a_re=0 and a_addr < DEPTH.
  - Only the lanes with a_be[i]=1 are updated.
  - If a_be is all zero, the write is a no-op with no error.
- In RUN, a port A read occurs when a_re=1, a_we=0 and a_addr < DEPTH.
  - a_rdata is loaded with mem[a_addr] and a_rvalid pulses.
- a_re=1 and a_we=1 together: neither operation is performed, a_err pulses, a_rdata holds its value.
- Port A address ≥ DEPTH, with re or we asserted:
  - The write is dropped.
  - A read returns 0 with a_rvalid=1.
  - a_err pulses in both cases.
- Port B read in RUN: b_rdata is loaded with mem[b_addr] and b_rvalid pulses. If b_addr ≥ DEPTH, b_rdata is 0 and b_rvalid still pulses.
- Both ports may address the same word in the same cycle.
  - A port A write plus a port B read of that word behaves as described under Configuration.
  - A read on both ports returns the same data on each.
- When no read is performed, a_rdata and b_rdata hold their last values.

## Timing
- Reset values:
  - a_rdata=0, b_rdata=0
  - a_rvalid=0, b_rvalid=0, a_err=0
  - init_busy=1, FSM=INIT, cnt=0
- The array contents are not reset directly; the sequencer clears them.
- init_busy deasserts on the same edge the FSM enters RUN. The first request is accepted on the first edge where init_busy was sampled 0.
- Total clear time is DEPTH cycles after rst deasserts.
- Read latency is 1 cycle. A request sampled at edge N produces rdata/rvalid valid from edge N until edge N+1.
- Write-then-read: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Back-to-back reads are accepted every cycle on both ports.
- a_err is registered and aligned to the cycle the request was sampled.
- If rst asserts mid-clear or mid-run, outputs return to reset values immediately and the clear restarts from address 0.

## Configuration
- DM_BYPASS_EN defined: on a same-cycle, same-address port A write and port B read, b_rdata returns the written data. Enabled lanes come from a_wdata; disabled lanes come from the old word.
- DM_BYPASS_EN undefined: the same collision returns the old word (read-before-write). The write still completes.

## Test plan
- Clear sequence: assert rst, release, count cycles. Expect init_busy high for exactly DEPTH cycles (8192 at defaults). Then a port B read of addresses 0, 100 and 8191 each returns 0x00000000.
- Byte-enable write: write 0xDEADBEEF with a_be=4'b1111 to address 5, then write 0x000000AA with a_be=4'b0001. Expect a port A read of address 5 to return 0xDEADBEAA, with a_rvalid one cycle later.
- Illegal requests:
  - a_re=a_we=1 at address 7 gives an a_err pulse and leaves mem[7] unchanged.
  - a_addr=8192 with DEPTH=4096 gives a_err=1 and a read returning 0.
- Cross-port collision: mem[9]=0x11111111; write 0x22222222 with a_be=4'b0011 while port B reads address 9. Expect b_rdata=0x11112222 with DM_BYPASS_EN defined, and 0x11111111 without. In both builds a later read returns 0x11112222.
- Reset mid-operation:
  - Write 0x12345678 to address 3, assert rst for one cycle during a pending read, then wait for init_busy to fall. Expect all outputs at reset values during rst, and a read of address 3 after the clear returns 0.
  - Repeat with rst asserted mid-clear; expect the full DEPTH-cycle clear to restart.

Source files
------------

// File: rtl/dm_dual_param.sv
// Dual-port data memory: byte-enabled CPU load/store port A, read-only port B, zero-cleared by a sequencer after reset.
// Build macro DM_BYPASS_EN forwards a same-cycle port A write into a colliding port B read.
module dm_dual_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic                  a_re,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_rvalid,
  output logic                  a_err,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic                  b_re,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_rvalid,
  output logic                  init_busy
);

  localparam int              NB       = DATA_W / 8;
  localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IW-1:0]   CNT_LAST = IW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run, a_ok, b_ok, a_rd, a_wr, a_bad, b_rd;
  logic [IW-1:0]     a_idx, b_idx;
  logic [DATA_W-1:0] b_word;

  assign run   = (state_q == RUN);
  assign a_ok  = ({1'b0, a_addr} < DEPTH_X);
  assign b_ok  = ({1'b0, b_addr} < DEPTH_X);
  assign a_idx = a_addr[IW-1:0];
  assign b_idx = b_addr[IW-1:0];
  assign a_rd  = run & a_re & ~a_we;
  assign a_wr  = run & a_we & ~a_re & a_ok;
  // Out-of-range reads and writes, and simultaneous re+we, are all flagged.
  assign a_bad = run & (a_re | a_we) & (~a_ok | (a_re & a_we));
  assign b_rd  = run & b_re;
  assign init_busy = (state_q == INIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    b_word = b_ok ? mem[b_idx] : '0;
`ifdef DM_BYPASS_EN
    if (a_wr && (a_addr == b_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) b_word[8*i +: 8] = a_wdata[8*i +: 8];
      end
    end
`endif
  end

  // Array has no reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (a_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      a_err    <= a_bad;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= a_ok ? mem[a_idx] : '0;
      if (b_rd) b_rdata <= b_word;
    end
  end

endmodule

// File: tb/tb_dm_dual_param.sv
// Bench for dm_dual_param: directed vector table, reset/clear sequences, and random traffic against a memory model.
module tb_dm_dual_param;
  localparam int DW = 32;
  localparam int AW = 14;
  localparam int DP = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_re, a_we, b_re;
  logic [3:0]    a_be;
  logic [DW-1:0] a_wdata, a_rdata, b_rdata;
  logic          a_rvalid, a_err, b_rvalid, init_busy;

  int total = 0;
  int bad   = 0;

  dm_dual_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_re(a_re), .a_we(a_we), .a_be(a_be), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_err(a_err),
    .b_addr(b_addr), .b_re(b_re), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          re, we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          bre;
    logic [AW-1:0] baddr;
    logic [DW-1:0] ard;
    logic          arv, aerr;
    logic [DW-1:0] brd;
    logic          brv;
  } vec_t;

  vec_t tbl [16];

  logic [DW-1:0] model [DP];
  logic [DW-1:0] e_ard, e_brd;
  logic          e_arv, e_aerr, e_brv;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic bre, input logic [AW-1:0] baddr);
    a_re = re; a_we = we; a_be = be; a_addr = addr; a_wdata = wd; b_re = bre; b_addr = baddr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_rdata"}, a_rdata, 32'h0);
    chk({tag, "_b_rdata"}, b_rdata, 32'h0);
    chk({tag, "_pulses"}, {29'h0, a_rvalid, a_err, b_rvalid}, 32'h0);
    chk({tag, "_init_busy"}, {31'h0, init_busy}, 32'h1);
  endtask

  // Counts edges from rst release until init_busy falls; requests must stay ignored meanwhile.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (init_busy === 1'b1 && n < DP + 8) begin
      step();
      n++;
      chk({tag, "_quiet"}, {29'h0, a_rvalid, a_err, b_rvalid}, 32'h0);
    end
    chk({tag, "_cycles"}, n, DP);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_reset({tag, "_async"});
    step();
    chk_reset({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic re, input logic we, input logic [3:0] be, input int addr,
                              input logic [DW-1:0] wd, input logic bre, input int baddr,
                              input logic [DW-1:0] ard, input logic arv, input logic aerr,
                              input logic [DW-1:0] brd, input logic brv);
    vec_t v;
    v.re = re; v.we = we; v.be = be; v.addr = AW'(addr); v.wd = wd;
    v.bre = bre; v.baddr = AW'(baddr);
    v.ard = ard; v.arv = arv; v.aerr = aerr; v.brd = brd; v.brv = brv;
    return v;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [3:0] be);
    logic [DW-1:0] m = old;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = nw[8*i +: 8];
    return m;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(0, 15));
      1:       return AW'($urandom_range(DP - 8, DP - 1));
      2:       return AW'($urandom_range(DP, DP + 7));
      default: return AW'($urandom_range(0, (1 << AW) - 1));
    endcase
  endfunction

  initial begin
    logic [DW-1:0] collide;
    int r, ai, bi;
    logic a_in, b_in, wr;

`ifdef DM_BYPASS_EN
    collide = 32'h11112222;
`else
    collide = 32'h11111111;
`endif
    //           re  we  be    addr  wdata         bre bad   a_rdata       arv aerr b_rdata       brv
    tbl[0]  = mk(0,  1, 4'hF,  5,    32'hDEADBEEF, 0,  0,    32'h0,        0,  0,   32'h0,        0);
    tbl[1]  = mk(0,  1, 4'h1,  5,    32'h000000AA, 0,  0,    32'h0,        0,  0,   32'h0,        0);
    tbl[2]  = mk(1,  0, 4'h0,  5,    32'h0,        0,  0,    32'hDEADBEAA, 1,  0,   32'h0,        0);
    tbl[3]  = mk(0,  0, 4'h0,  0,    32'h0,        0,  0,    32'hDEADBEAA, 0,  0,   32'h0,        0);
    tbl[4]  = mk(1,  1, 4'hF,  7,    32'hFFFFFFFF, 0,  0,    32'hDEADBEAA, 0,  1,   32'h0,        0);
    tbl[5]  = mk(1,  0, 4'h0,  7,    32'h0,        0,  0,    32'h0,        1,  0,   32'h0,        0);
    tbl[6]  = mk(1,  0, 4'h0,  5,    32'h0,        0,  0,    32'hDEADBEAA, 1,  0,   32'h0,        0);
    tbl[7]  = mk(1,  0, 4'h0,  8192, 32'h0,        0,  0,    32'h0,        1,  1,   32'h0,        0);
    tbl[8]  = mk(0,  1, 4'hF,  8192, 32'h55555555, 0,  0,    32'h0,        0,  1,   32'h0,        0);
    tbl[9]  = mk(1,  0, 4'h0,  0,    32'h0,        0,  0,    32'h0,        1,  0,   32'h0,        0);
    tbl[10] = mk(0,  1, 4'hF,  9,    32'h11111111, 0,  0,    32'h0,        0,  0,   32'h0,        0);
    tbl[11] = mk(0,  1, 4'h3,  9,    32'h22222222, 1,  9,    32'h0,        0,  0,   collide,      1);
    tbl[12] = mk(1,  0, 4'h0,  9,    32'h0,        1,  9,    32'h11112222, 1,  0,   32'h11112222, 1);
    tbl[13] = mk(0,  1, 4'h0,  9,    32'hFFFFFFFF, 0,  0,    32'h11112222, 0,  0,   32'h11112222, 0);
    tbl[14] = mk(0,  0, 4'h0,  0,    32'h0,        1,  9,    32'h11112222, 0,  0,   32'h11112222, 1);
    tbl[15] = mk(0,  0, 4'h0,  0,    32'h0,        1,  8191, 32'h11112222, 0,  0,   32'h0,        1);

    rst = 1'b1;
    idle();
    #3;
    chk_reset("por");
    // Requests during the clear must be ignored, including this write to address 0.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 4'hF, '0, 32'hFFFFFFFF, 1'b1, '0);
    wait_clear("clear0");
    idle();

    drive(1'b1, 1'b0, 4'h0, '0, '0, 1'b1, AW'(0));
    step();
    chk("clr_a0", a_rdata, 32'h0);
    chk("clr_b0_rv", {31'h0, b_rvalid}, 32'h1);
    drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, AW'(100));
    step();
    chk("clr_b100", b_rdata, 32'h0);
    drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, AW'(8191));
    step();
    chk("clr_b8191", b_rdata, 32'h0);
    idle();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].re, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, tbl[i].bre, tbl[i].baddr);
      step();
      chk($sformatf("v%0d_a_rdata", i), a_rdata, tbl[i].ard);
      chk($sformatf("v%0d_a_rvalid", i), {31'h0, a_rvalid}, {31'h0, tbl[i].arv});
      chk($sformatf("v%0d_a_err", i), {31'h0, a_err}, {31'h0, tbl[i].aerr});
      chk($sformatf("v%0d_b_rdata", i), b_rdata, tbl[i].brd);
      chk($sformatf("v%0d_b_rvalid", i), {31'h0, b_rvalid}, {31'h0, tbl[i].brv});
    end
    idle();

    // Reset during a pending read after a nonzero word was returned on both ports.
    drive(1'b0, 1'b1, 4'hF, AW'(3), 32'h12345678, 1'b0, '0);
    step();
    drive(1'b1, 1'b0, 4'h0, AW'(3), '0, 1'b1, AW'(3));
    step();
    chk("rr_a_pre", a_rdata, 32'h12345678);
    chk("rr_b_pre", b_rdata, 32'h12345678);
    #2;
    do_reset("rr");
    idle();
    wait_clear("rr_clear");
    drive(1'b1, 1'b0, 4'h0, AW'(3), '0, 1'b0, '0);
    step();
    chk("rr_a3", a_rdata, 32'h0);
    chk("rr_a3_rv", {31'h0, a_rvalid}, 32'h1);

    // Reset in the middle of a clear restarts the whole sweep.
    drive(1'b0, 1'b1, 4'hF, AW'(DP - 1), 32'hCAFEF00D, 1'b0, '0);
    step();
    idle();
    do_reset("mc0");
    repeat (1000) step();
    chk("mc_busy", {31'h0, init_busy}, 32'h1);
    do_reset("mc1");
    wait_clear("mc_clear");
    drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, AW'(DP - 1));
    step();
    chk("mc_b_last", b_rdata, 32'h0);
    idle();

    for (int i = 0; i < DP; i++) model[i] = '0;
    e_ard = a_rdata === 32'h0 ? 32'h0 : 32'hFFFFFFFF;
    e_ard = 32'h0;
    e_brd = 32'h0;
    for (int t = 0; t < 3000; t++) begin
      r = $urandom_range(0, 9);
      a_addr  = pick_addr();
      a_re    = (r <= 3) || (r == 8);
      a_we    = (r >= 4 && r <= 8);
      a_be    = 4'($urandom_range(0, 15));
      a_wdata = $urandom;
      b_re    = ($urandom_range(0, 9) < 7);
      b_addr  = ($urandom_range(0, 1) == 1) ? a_addr : pick_addr();

      ai = int'(a_addr);
      bi = int'(b_addr);
      a_in = (ai < DP);
      b_in = (bi < DP);
      wr = a_we && !a_re && a_in;
      e_brv = b_re;
      if (b_re) begin
        e_brd = b_in ? model[bi] : 32'h0;
`ifdef DM_BYPASS_EN
        if (wr && ai == bi) e_brd = merge(model[ai], a_wdata, a_be);
`endif
      end
      e_arv = 1'b0;
      e_aerr = 1'b0;
      if (a_re && a_we) begin
        e_aerr = 1'b1;
      end else if (a_re) begin
        e_arv  = 1'b1;
        e_ard  = a_in ? model[ai] : 32'h0;
        e_aerr = !a_in;
      end else if (a_we) begin
        if (a_in) model[ai] = merge(model[ai], a_wdata, a_be);
        else e_aerr = 1'b1;
      end

      step();
      chk($sformatf("rnd%0d_a_rdata", t), a_rdata, e_ard);
      chk($sformatf("rnd%0d_a_flags", t), {30'h0, a_rvalid, a_err}, {30'h0, e_arv, e_aerr});
      chk($sformatf("rnd%0d_b_rdata", t), b_rdata, e_brd);
      chk($sformatf("rnd%0d_b_rvalid", t), {31'h0, b_rvalid}, {31'h0, e_brv});
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
